iob_axi_wr_burst_split: RTL
===========================

// Module: iob_axi_wr_burst_split
// PURPOSE
//  Upstream feeder for the native-to-AXI4 write burst engine. Takes one write
//  transfer (word address + word count) and a data stream, and splits it into
//  INCR bursts. Each burst is at most MAX_BURST beats and never crosses a 4 KB
//  boundary. It drives the engine's control/native I/F and merges the
//  per-burst write-response errors into one transfer error.
// PARAMETERS
//  ADDR_W     32   byte-address width
//  DATA_W     32   data width; BYTES = DATA_W/8
//  CNT_W      16   width of the transfer word count
//  MAX_BURST  256  max beats per burst; power of two, 1..256
// PORTS
//  clk         in   1          clock
//  rst         in   1          synchronous, active-high reset
//  start       in   1          transfer request; sampled only in IDLE
//  base_addr   in   ADDR_W     transfer start byte address; low log2(BYTES) bits forced 0
//  nwords      in   CNT_W      number of DATA_W words to write
//  busy        out  1          transfer in progress
//  done        out  1          1-cycle pulse at transfer end
//  error       out  1          OR of all burst bresp errors of the last transfer
//  in_valid    in   1          data stream valid
//  in_data     in   DATA_W     data stream word
//  in_strb     in   DATA_W/8   data stream byte strobes
//  in_ready    out  1          data stream ready
//  wr_length   out  AXI_LEN_W  burst beats-1 to engine
//  wr_ready    in   1          engine idle/ready for a new burst
//  wr_error    in   1          engine error, valid when wr_ready returns high
//  wr_valid    out  1          native valid to engine
//  wr_addr     out  ADDR_W     burst start address, held for the whole burst
//  wr_wdata    out  DATA_W     = in_data
//  wr_wstrb    out  DATA_W/8   = in_strb
//  wr_sready   in   1          engine beat accept
// BEHAVIOUR
//  Reset: state IDLE; busy, done, error, wr_valid and in_ready are 0;
//   wr_length, wr_addr and the internal counters are 0.
//  A reset mid-transfer aborts. It does not flush the engine or drain in_*.
//  States: IDLE -> CALC -> BURST -> RESP -> (CALC | IDLE).
//  IDLE
//   - start=1, nwords!=0: latch addr and remaining=nwords; busy=1; go to CALC.
//   - start=1, nwords==0: no burst; done=1 and error=0 on the next cycle;
//     stay in IDLE.
//   - start while busy is ignored.
//   - error clears on an accepted start.
//  CALC (1 cycle)
//   - beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / BYTES).
//   - Register wr_length = beats-1 and wr_addr = addr.
//   - Use CNT_W+1-bit arithmetic; no truncation before the min.
//  BURST
//   - Entered only when wr_ready=1; otherwise wait in CALC.
//   - wr_valid = in_valid; in_ready = wr_sready.
//   - A beat transfers on in_valid & wr_sready.
//   - Beat count 0..beats-1. wr_addr and wr_length are stable for the whole
//     burst.
//   - After the final beat: addr += beats*BYTES, remaining -= beats; go to RESP.
//  RESP
//   - Ignore the first cycle (engine ready deasserts); then wait for
//     wr_ready=1.
//   - On wr_ready=1: error |= wr_error.
//   - remaining != 0 -> CALC.
//   - remaining == 0 -> IDLE with busy=0 and a 1-cycle done pulse.
//  Ordering and wrap
//   - Bursts are issued in ascending address order, one at a time, never
//     overlapped.
//   - An address wrap past 2^ADDR_W is undefined; this is the caller's
//     responsibility.
//  An error in an early burst does not stop later bursts.
// STRUCTURE
//  - Shared axi.vh header supplies AXI_LEN_W and the 4 KB boundary width
//    (AXI_4K_W = 12).
//  - One natural sub-module: iob_axi_burst_len. It is combinational and maps
//    (addr, remaining) to beats-1, with the same parameters. Instantiate it
//    in CALC.
//  - The FSM and counters stay in this module.
// TESTING (DATA_W=32, MAX_BURST=256; bench engine model answers bresp per burst)
//  1. base 0x1000, nwords 16 -> one burst: addr 0x1000, len 15, 16 beats;
//     done pulse; error 0.
//  2. base 0x0FF0, nwords 8 -> burst addr 0xFF0 len 3, then addr 0x1000 len 3;
//     one done.
//  3. base 0x0, nwords 300 -> len 255 @0x0, then len 43 @0x400; data order
//     preserved.
//  4. Random in_valid gaps and wr_sready stalls -> no beat lost or duplicated;
//     wr_addr/wr_length stable within each burst.
//  5. wr_error=1 on burst 1 of 2 -> burst 2 is still issued; error=1 at done;
//     the next start clears error.
//  6. nwords 0 -> done 1 cycle after start, no wr_valid. rst mid-burst ->
//     next cycle busy=0, wr_valid=0; a new start is accepted.

Source files
------------

// File: rtl/iob_axi_wr_burst_split_pkg.sv
// Shared AXI constants and FSM state encoding for the write burst splitter.
package iob_axi_wr_burst_split_pkg;

    localparam int AXI_LEN_W = 8;
    localparam int AXI_4K_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_BURST = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/iob_axi_burst_len.sv
// Combinational burst sizer: beats-1 = min(remaining, MAX_BURST, words left in the 4 KB page) - 1.
module iob_axi_burst_len
    import iob_axi_wr_burst_split_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 256
) (
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [CNT_W-1:0]     i_remaining,
    output logic [AXI_LEN_W-1:0] o_len
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    // Wide enough for both the full word count and the 4096-byte page size.
    localparam int MW    = (CNT_W + 1 > AXI_4K_W + 2) ? CNT_W + 1 : AXI_4K_W + 2;

    logic [MW-1:0] w_rem;
    logic [MW-1:0] w_room;
    logic [MW-1:0] w_max;
    logic [MW-1:0] w_min1;
    logic [MW-1:0] w_beats;
    logic          w_unused;

    assign w_unused = ^i_addr[ADDR_W-1:AXI_4K_W];

    assign w_rem   = MW'(i_remaining);
    assign w_room  = ((MW'(1) << AXI_4K_W) - MW'(i_addr[AXI_4K_W-1:0])) >> BSH;
    assign w_max   = MW'(MAX_BURST);
    assign w_min1  = (w_rem < w_max) ? w_rem : w_max;
    assign w_beats = (w_min1 < w_room) ? w_min1 : w_room;
    assign o_len   = AXI_LEN_W'(w_beats - MW'(1));

endmodule

// File: rtl/iob_axi_wr_burst_split.sv
// Splits one native write transfer into 4 KB-safe INCR bursts for the AXI4 write engine
// and merges the per-burst responses into a single transfer error.
module iob_axi_wr_burst_split
    import iob_axi_wr_burst_split_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]      nwords,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_strb,
    output logic                  in_ready,
    output logic [AXI_LEN_W-1:0]  wr_length,
    input  logic                  wr_ready,
    input  logic                  wr_error,
    output logic                  wr_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_wdata,
    output logic [DATA_W/8-1:0]   wr_wstrb,
    input  logic                  wr_sready
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [CNT_W-1:0]       r_rem;
    logic [AXI_LEN_W-1:0]   r_beat;
    logic [AXI_LEN_W-1:0]   r_len;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic                   r_err;
    logic                   r_done;
    logic                   r_resp_first;

    logic [AXI_LEN_W-1:0]   w_len;
    logic [AXI_LEN_W:0]     w_beats;
    logic                   w_xfer;
    logic                   w_last;
    logic                   w_resp_ok;

    iob_axi_burst_len #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_len (
        .i_addr      (r_addr),
        .i_remaining (r_rem),
        .o_len       (w_len)
    );

    assign w_beats   = (AXI_LEN_W+1)'(r_len) + (AXI_LEN_W+1)'(1);
    assign w_xfer    = (r_state == ST_BURST) && in_valid && wr_sready;
    assign w_last    = (r_beat == r_len);
    // The engine drops wr_ready one cycle late, so the first RESP cycle is not a response.
    assign w_resp_ok = (r_state == ST_RESP) && !r_resp_first && wr_ready;

    assign wr_length = r_len;
    assign wr_addr   = r_wr_addr;
    assign wr_wdata  = in_data;
    assign wr_wstrb  = in_strb;
    assign done      = r_done;
    assign error     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start && (nwords != '0)) w_next = ST_CALC;
            ST_CALC:  if (wr_ready) w_next = ST_BURST;
            ST_BURST: if (w_xfer && w_last) w_next = ST_RESP;
            ST_RESP:  if (w_resp_ok) w_next = (r_rem != '0) ? ST_CALC : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        wr_valid = 1'b0;
        in_ready = 1'b0;
        if (r_state == ST_BURST) begin
            wr_valid = in_valid;
            in_ready = wr_sready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_rem        <= '0;
            r_beat       <= '0;
            r_len        <= '0;
            r_wr_addr    <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_resp_first <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (nwords == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr <= base_addr & ~ADDR_W'(BYTES - 1);
                            r_rem  <= nwords;
                        end
                    end
                end
                ST_CALC: begin
                    r_len     <= w_len;
                    r_wr_addr <= r_addr;
                    r_beat    <= '0;
                end
                ST_BURST: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_addr       <= r_addr + (ADDR_W'(w_beats) << BSH);
                            r_rem        <= r_rem - CNT_W'(w_beats);
                            r_resp_first <= 1'b1;
                        end else begin
                            r_beat <= r_beat + AXI_LEN_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    r_resp_first <= 1'b0;
                    if (w_resp_ok) begin
                        r_err <= r_err | wr_error;
                        if (r_rem == '0) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
